ula_sequencial: RTL

- Multicycle execution unit (ULA) on the consumer side of the `ula_op` interface. It accepts the 4-bit `ula_op` code produced by the ALU control decoder, plus two operands, through a start/busy/done handshake.
- AND, OR, ADD, SUB and SLT complete in one cycle.
- Logical shifts run iteratively, one bit per cycle, through a small FSM.
- Sits in the execute stage, between the ALU control decoder and the register-file write-back mux.

---
 rtl/ula_sequencial.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/ula_sequencial.sv
// ula_sequencial: multicycle execution unit (ULA) for the execute stage.
//
// Accepts a 4-bit ula_op from the ALU control decoder plus two operands
// through a start/busy/done handshake. AND, OR, ADD, SUB and SLT finish in
// one cycle. SLL and SRL shift one bit per cycle in a two-state FSM.
//
// Handshake: start is accepted on a rising edge only while busy=0 (FSM idle).
// a, b and ula_op are captured on that edge. done is a one-cycle pulse that
// marks resultado/zero/erro as valid. Outputs hold until the next accept.
// A start while busy=1 is ignored.
//
// Optional feature: define ULA_OVERFLOW_EN to add the registered `overflow`
// output (signed overflow of ADD/SUB).
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      operation request
//   ula_op     operation code (AND 0000, OR 0001, ADD 0010, SUB 0110,
//              SLT 0111, SLL 0011, SRL 0100; all others invalid)
//   a, b       operands; b[SHW-1:0] is the shift amount
//   busy       high while a shift iterates
//   done       one-cycle result-valid pulse
//   resultado  registered result
//   zero       resultado == 0
//   erro       last accepted ula_op was invalid
//   overflow   (ULA_OVERFLOW_EN only) signed overflow of ADD/SUB
module ula_sequencial #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ula_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] resultado,
  output logic             zero,
  output logic             erro
`ifdef ULA_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;

  localparam logic [0:0] OCIOSO  = 1'b0;
  localparam logic [0:0] DESLOCA = 1'b1;

  // FSM state; kept as a named signal so checkers can bind to it.
  logic [0:0]       state;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   cnt;
  logic             dir_left;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] imm_res;
  logic             imm_err;
  logic             imm_shift;
  logic             slt_bit;
  logic [WIDTH-1:0] acc_next;
  logic             last_step;

  assign sum       = a + b;
  assign diff      = a - b;
  assign shamt     = b[SHW-1:0];
  assign slt_bit   = ($signed(a) < $signed(b));
  assign acc_next  = dir_left ? (acc << 1) : (acc >> 1);
  assign last_step = (cnt == SHW'(1));

`ifdef ULA_OVERFLOW_EN
  logic add_ovf;
  logic sub_ovf;
  logic imm_ovf;

  // Signed overflow: ADD when same-sign operands give a different-sign
  // result; SUB when the operands differ in sign and the result differs from a.
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  assign imm_ovf = (ula_op == OP_ADD) ? add_ovf :
                   (ula_op == OP_SUB) ? sub_ovf : 1'b0;
`endif

  // Result of an operation that completes at the accept edge. A shift with
  // shamt=0 also completes immediately and returns a unchanged; only a
  // non-zero shift amount enters the iterating state.
  always_comb begin
    imm_res   = '0;
    imm_err   = 1'b0;
    imm_shift = 1'b0;
    case (ula_op)
      OP_AND:  imm_res = a & b;
      OP_OR:   imm_res = a | b;
      OP_ADD:  imm_res = sum;
      OP_SUB:  imm_res = diff;
      OP_SLT:  imm_res = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_SLL, OP_SRL: begin
        if (shamt == '0) imm_res = a;
        else             imm_shift = 1'b1;
      end
      default: imm_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= OCIOSO;
      busy      <= 1'b0;
      done      <= 1'b0;
      resultado <= '0;
      zero      <= 1'b1;
      erro      <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      dir_left  <= 1'b0;
`ifdef ULA_OVERFLOW_EN
      overflow  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        OCIOSO: begin
          if (start) begin
            if (imm_shift) begin
              acc      <= a;
              cnt      <= shamt;
              dir_left <= (ula_op == OP_SLL);
              state    <= DESLOCA;
              busy     <= 1'b1;
              erro     <= 1'b0;
            end else begin
              resultado <= imm_res;
              zero      <= (imm_res == '0);
              erro      <= imm_err;
              done      <= 1'b1;
`ifdef ULA_OVERFLOW_EN
              overflow  <= imm_ovf;
`endif
            end
          end
        end
        DESLOCA: begin
          // start is deliberately not looked at here: requests during a
          // shift are dropped, not queued.
          acc <= acc_next;
          cnt <= cnt - SHW'(1);
          if (last_step) begin
            resultado <= acc_next;
            zero      <= (acc_next == '0);
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= OCIOSO;
`ifdef ULA_OVERFLOW_EN
            overflow  <= 1'b0;
`endif
          end
        end
        default: begin
          state <= OCIOSO;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
